// File: rtl/pll_reconfig_seq.sv
// -----------------------------------------------------------------------------
// pll_reconfig_seq
//
// Purpose:
//   Sequences a fractional-PLL profile switch through the PLL reconfiguration
//   management slave. On an accepted profile request it writes
//   mode (addr 0), fractional K (addr 7) and start (addr 2). Consecutive writes
//   are separated by exactly one idle gap cycle. It optionally waits for the
//   PLL to drop and regain lock, with a timeout. It then pulses done and
//   commits the new active profile.
//
// Configuration macro:
//   PLL_RECONFIG_LOCK_WAIT_EN  defined   -> unlock/lock wait, shared wait
//                                           counter and timeout flag are built.
//                              undefined -> sequence ends right after the start
//                                           write is accepted; pll_locked is
//                                           ignored and timeout stays 0.
//
// Ports:
//   clk_50m           in   management clock, all logic on the rising edge
//   reset             in   synchronous active-high reset
//   profile_sel       in   requested profile (0 native, 1 alt), asynchronous
//   mgmt_waitrequest  in   reconfig slave stall
//   pll_locked        in   PLL lock indicator, asynchronous
//   mgmt_write        out  write strobe
//   mgmt_address      out  [5:0] register address (0 when not writing)
//   mgmt_writedata    out  [31:0] register data (0 when not writing)
//   busy              out  high whenever the sequencer is not idle
//   active_profile    out  profile most recently applied
//   done              out  one-cycle pulse at sequence completion
//   timeout           out  sticky lock-timeout flag, cleared at next start
// -----------------------------------------------------------------------------
module pll_reconfig_seq #(
   parameter logic [31:0] K_NATIVE     = 32'd3639383488,
   parameter logic [31:0] K_ALT        = 32'd3262113561,
   parameter logic [23:0] LOCK_TIMEOUT = 24'd5000000
) (
   input  logic        clk_50m,
   input  logic        reset,
   input  logic        profile_sel,
   input  logic        mgmt_waitrequest,
   input  logic        pll_locked,
   output logic        mgmt_write,
   output logic [5:0]  mgmt_address,
   output logic [31:0] mgmt_writedata,
   output logic        busy,
   output logic        active_profile,
   output logic        done,
   output logic        timeout
);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      W_MODE      = 3'd1,
      W_KFRAC     = 3'd2,
      W_START     = 3'd3,
      GAP         = 3'd4,
      WAIT_UNLOCK = 3'd5,
      WAIT_LOCK   = 3'd6
   } state_t;

   // synchronizers and request qualification
   logic        prof_meta_r;
   logic        prof_sync_r;
   logic        prof_prev_r;
   logic [1:0]  fill_r;
   logic        lock_meta_r;
   logic        lock_sync_r;
   logic        stable_s;
   logic        req_s;

   // FSM state and registered outputs
   state_t      state_r;
   state_t      state_s;
   logic        target_r;
   logic        target_s;
   logic        gap_to_start_r;
   logic        gap_to_start_s;
   logic        write_r;
   logic        write_s;
   logic [5:0]  addr_r;
   logic [5:0]  addr_s;
   logic [31:0] data_r;
   logic [31:0] data_s;
   logic        busy_r;
   logic        busy_s;
   logic        done_r;
   logic        done_s;
   logic        active_r;
   logic        active_s;
   logic        timeout_r;
   logic        timeout_s;
   logic        startup_r;
   logic        startup_s;
   logic [31:0] k_sel_s;

`ifdef PLL_RECONFIG_LOCK_WAIT_EN
   logic [23:0] cnt_r;
   logic [23:0] cnt_s;
   logic [23:0] tmo_last_s;

   assign tmo_last_s = LOCK_TIMEOUT - 24'd1;
`else
   // Lock input and timeout parameter have no function in this build.
   logic        unused_lock_s;

   assign unused_lock_s = ^{lock_sync_r, LOCK_TIMEOUT};
`endif

   // The synchronizer chain needs three real samples (meta, sync, prev) before
   // a "stable for two cycles" decision is meaningful; fill_r tracks that.
   assign stable_s = (fill_r == 2'd3) && (prof_sync_r == prof_prev_r);
   // Startup forces the first stable sample through even if it equals the
   // reset value of active_profile.
   assign req_s    = stable_s && (startup_r || (prof_sync_r != active_r));
   assign k_sel_s  = target_r ? K_ALT : K_NATIVE;

   // Two-FF synchronizers plus one history stage for the stability check.
   always_ff @(posedge clk_50m) begin
      if (reset) begin
         prof_meta_r <= 1'b0;
         prof_sync_r <= 1'b0;
         prof_prev_r <= 1'b0;
         fill_r      <= 2'd0;
         lock_meta_r <= 1'b0;
         lock_sync_r <= 1'b0;
      end else begin
         prof_meta_r <= profile_sel;
         prof_sync_r <= prof_meta_r;
         prof_prev_r <= prof_sync_r;
         fill_r      <= (fill_r == 2'd3) ? 2'd3 : (fill_r + 2'd1);
         lock_meta_r <= pll_locked;
         lock_sync_r <= lock_meta_r;
      end
   end

   // Next-state and next-output decode; bus outputs default to an idle bus.
   always_comb begin
      state_s        = state_r;
      target_s       = target_r;
      gap_to_start_s = gap_to_start_r;
      write_s        = 1'b0;
      addr_s         = 6'd0;
      data_s         = 32'd0;
      done_s         = 1'b0;
      active_s       = active_r;
      timeout_s      = timeout_r;
      startup_s      = startup_r;
`ifdef PLL_RECONFIG_LOCK_WAIT_EN
      cnt_s          = cnt_r;
`endif
      case (state_r)
         IDLE: begin
            if (req_s) begin
               state_s   = W_MODE;
               target_s  = prof_sync_r;
               startup_s = 1'b0;
               timeout_s = 1'b0;
               write_s   = 1'b1;
            end else begin
               state_s   = IDLE;
            end
         end
         W_MODE: begin
            // Hold the write unchanged until the slave stops stalling.
            if (mgmt_waitrequest) begin
               write_s        = 1'b1;
            end else begin
               state_s        = GAP;
               gap_to_start_s = 1'b0;
            end
         end
         W_KFRAC: begin
            if (mgmt_waitrequest) begin
               write_s        = 1'b1;
               addr_s         = 6'd7;
               data_s         = k_sel_s;
            end else begin
               state_s        = GAP;
               gap_to_start_s = 1'b1;
            end
         end
         GAP: begin
            // Single idle cycle; gap_to_start_r selects which write follows.
            write_s = 1'b1;
            if (gap_to_start_r) begin
               state_s = W_START;
               addr_s  = 6'd2;
            end else begin
               state_s = W_KFRAC;
               addr_s  = 6'd7;
               data_s  = k_sel_s;
            end
         end
         W_START: begin
            if (mgmt_waitrequest) begin
               write_s  = 1'b1;
               addr_s   = 6'd2;
            end else begin
`ifdef PLL_RECONFIG_LOCK_WAIT_EN
               state_s  = WAIT_UNLOCK;
               cnt_s    = 24'd0;
`else
               state_s  = IDLE;
               done_s   = 1'b1;
               active_s = target_r;
`endif
            end
         end
`ifdef PLL_RECONFIG_LOCK_WAIT_EN
         WAIT_UNLOCK: begin
            // The counter keeps running into WAIT_LOCK so the timeout covers
            // the whole unlock-plus-relock window.
            cnt_s = cnt_r + 24'd1;
            if (cnt_r == tmo_last_s) begin
               state_s   = IDLE;
               timeout_s = 1'b1;
               done_s    = 1'b1;
               active_s  = target_r;
            end else if (!lock_sync_r || (cnt_r == 24'd63)) begin
               state_s   = WAIT_LOCK;
            end else begin
               state_s   = WAIT_UNLOCK;
            end
         end
         WAIT_LOCK: begin
            cnt_s = cnt_r + 24'd1;
            if (lock_sync_r) begin
               state_s   = IDLE;
               done_s    = 1'b1;
               active_s  = target_r;
            end else if (cnt_r == tmo_last_s) begin
               state_s   = IDLE;
               timeout_s = 1'b1;
               done_s    = 1'b1;
               active_s  = target_r;
            end else begin
               state_s   = WAIT_LOCK;
            end
         end
`endif
         default: begin
            state_s = IDLE;
         end
      endcase
      busy_s = (state_s != IDLE);
   end

   // State and registered-output update.
   always_ff @(posedge clk_50m) begin
      if (reset) begin
         state_r        <= IDLE;
         target_r       <= 1'b0;
         gap_to_start_r <= 1'b0;
         write_r        <= 1'b0;
         addr_r         <= 6'd0;
         data_r         <= 32'd0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         active_r       <= 1'b0;
         timeout_r      <= 1'b0;
         startup_r      <= 1'b1;
      end else begin
         state_r        <= state_s;
         target_r       <= target_s;
         gap_to_start_r <= gap_to_start_s;
         write_r        <= write_s;
         addr_r         <= addr_s;
         data_r         <= data_s;
         busy_r         <= busy_s;
         done_r         <= done_s;
         active_r       <= active_s;
         timeout_r      <= timeout_s;
         startup_r      <= startup_s;
      end
   end

`ifdef PLL_RECONFIG_LOCK_WAIT_EN
   // Shared unlock/lock wait counter.
   always_ff @(posedge clk_50m) begin
      if (reset) begin
         cnt_r <= 24'd0;
      end else begin
         cnt_r <= cnt_s;
      end
   end
`endif

   assign mgmt_write     = write_r;
   assign mgmt_address   = addr_r;
   assign mgmt_writedata = data_r;
   assign busy           = busy_r;
   assign done           = done_r;
   assign active_profile = active_r;
   assign timeout        = timeout_r;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_reconfig_seq
//
// Directed bench for pll_reconfig_seq: reset state, startup sequence, stalled
// K write, profile changes during a sequence, glitch rejection, reset in the
// middle of a stalled write and (lock-wait build only) lock timeout.
// -----------------------------------------------------------------------------
module tb_pll_reconfig_seq;

   localparam logic [31:0] K_NATIVE = 32'd3639383488;
   localparam logic [31:0] K_ALT    = 32'd3262113561;

   logic        clk_50m = 1'b0;
   logic        reset;
   logic        profile_sel;
   logic        mgmt_waitrequest;
   logic        pll_locked;
   logic        mgmt_write;
   logic [5:0]  mgmt_address;
   logic [31:0] mgmt_writedata;
   logic        busy;
   logic        active_profile;
   logic        done;
   logic        timeout;

   int vec_cnt = 0;
   int err_cnt = 0;

   pll_reconfig_seq #(
      .K_NATIVE     (K_NATIVE),
      .K_ALT        (K_ALT),
      .LOCK_TIMEOUT (24'd100)
   ) dut (
      .clk_50m          (clk_50m),
      .reset            (reset),
      .profile_sel      (profile_sel),
      .mgmt_waitrequest (mgmt_waitrequest),
      .pll_locked       (pll_locked),
      .mgmt_write       (mgmt_write),
      .mgmt_address     (mgmt_address),
      .mgmt_writedata   (mgmt_writedata),
      .busy             (busy),
      .active_profile   (active_profile),
      .done             (done),
      .timeout          (timeout)
   );

   // 50 MHz management clock.
   always #10 clk_50m = ~clk_50m;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_50m);
      #1;
   endtask

   // Waits for a write, checks it, stalls it for 'stall' cycles, checks its
   // width and the idle bus afterwards, and for non-final writes checks that
   // exactly one gap cycle precedes the next write.
   task automatic observe_write(input string tag, input logic [5:0] exp_addr,
                                input logic [31:0] exp_data, input int stall,
                                input bit wiggle, input bit sel_final, input bit last);
      int n;
      int hold;
      bit held_ok;
      n = 0;
      mgmt_waitrequest = 1'b0;
      while (!mgmt_write && n < 100) begin
         tick();
         n++;
      end
      check_val({tag, "_wr"},   {31'd0, mgmt_write}, 32'd1);
      check_val({tag, "_addr"}, {26'd0, mgmt_address}, {26'd0, exp_addr});
      check_val({tag, "_data"}, mgmt_writedata, exp_data);
      check_val({tag, "_busy"}, {31'd0, busy}, 32'd1);
      hold    = 0;
      held_ok = 1'b1;
      while (mgmt_write && hold < 50) begin
         if (mgmt_address !== exp_addr || mgmt_writedata !== exp_data) held_ok = 1'b0;
         mgmt_waitrequest = (hold < stall);
         if (wiggle) begin
            if (hold < stall) profile_sel = ((hold % 2) == 0) ? ~sel_final : sel_final;
            else              profile_sel = sel_final;
         end
         tick();
         hold++;
      end
      mgmt_waitrequest = 1'b0;
      check_val({tag, "_held"},  {31'd0, held_ok}, 32'd1);
      check_val({tag, "_width"}, hold, stall + 1);
      check_val({tag, "_idlebus"}, {26'd0, mgmt_address} | mgmt_writedata, 32'd0);
      if (!last) begin
         tick();
         check_val({tag, "_gap1"}, {31'd0, mgmt_write}, 32'd1);
      end
   endtask

   // Full three-write sequence followed by completion checks.
   // lock_mode 0: lock drops for 10 cycles then returns; 1: lock stays low.
   task automatic run_seq(input string tag, input bit prof, input int kstall,
                          input bit wiggle, input bit sel_final,
                          input int lock_mode, input bit exp_to);
      int n;
      observe_write({tag, "_mode"},  6'd0, 32'd0, 0, 1'b0, 1'b0, 1'b0);
      observe_write({tag, "_kfrac"}, 6'd7, prof ? K_ALT : K_NATIVE, kstall, wiggle, sel_final, 1'b0);
      observe_write({tag, "_start"}, 6'd2, 32'd0, 0, 1'b0, 1'b0, 1'b1);
      n = 0;
      while (!done && n < 400) begin
         if (lock_mode == 1) pll_locked = 1'b0;
         else                pll_locked = (n >= 10);
         tick();
         n++;
      end
      pll_locked = 1'b1;
      check_val({tag, "_done"},    {31'd0, done}, 32'd1);
      check_val({tag, "_busy0"},   {31'd0, busy}, 32'd0);
      check_val({tag, "_active"},  {31'd0, active_profile}, {31'd0, prof});
      check_val({tag, "_timeout"}, {31'd0, timeout}, {31'd0, exp_to});
   endtask

   // No write may start during the given number of cycles.
   task automatic expect_quiet(input string tag, input int cycles);
      int wr_seen;
      wr_seen = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (mgmt_write) wr_seen++;
      end
      check_val({tag, "_nowrite"}, wr_seen, 0);
      check_val({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      reset            = 1'b1;
      profile_sel      = 1'b0;
      mgmt_waitrequest = 1'b0;
      pll_locked       = 1'b1;
      repeat (3) tick();

      // Reset state
      check_val("rst_write",   {31'd0, mgmt_write}, 32'd0);
      check_val("rst_addr",    {26'd0, mgmt_address}, 32'd0);
      check_val("rst_data",    mgmt_writedata, 32'd0);
      check_val("rst_busy",    {31'd0, busy}, 32'd0);
      check_val("rst_done",    {31'd0, done}, 32'd0);
      check_val("rst_timeout", {31'd0, timeout}, 32'd0);
      check_val("rst_active",  {31'd0, active_profile}, 32'd0);

      // Startup sequence to native profile
      reset = 1'b0;
      run_seq("startup", 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
      tick();
      check_val("startup_done_pulse", {31'd0, done}, 32'd0);
      expect_quiet("startup_after", 12);

      // Switch to alt with a 5-cycle stall on the K write
      profile_sel = 1'b1;
      run_seq("alt", 1'b1, 5, 1'b0, 1'b0, 0, 1'b0);
      expect_quiet("alt_after", 12);

      // Request native, wiggle during the flight ending on alt: one follow-up
      // sequence starts on the cycle right after done.
      profile_sel = 1'b0;
      run_seq("wig_b", 1'b0, 4, 1'b1, 1'b1, 0, 1'b0);
      tick();
      check_val("wig_b_next_write", {31'd0, mgmt_write}, 32'd1);
      check_val("wig_b_next_addr",  {26'd0, mgmt_address}, 32'd0);
      run_seq("wig_b2", 1'b1, 0, 1'b0, 1'b0, 0, 1'b0);
      expect_quiet("wig_b2_after", 12);

      // Request native, wiggle ending on the target: no second sequence
      profile_sel = 1'b0;
      run_seq("wig_a", 1'b0, 4, 1'b1, 1'b0, 0, 1'b0);
      expect_quiet("wig_a_after", 15);

      // One-cycle glitch in IDLE is rejected
      profile_sel = 1'b1;
      tick();
      profile_sel = 1'b0;
      expect_quiet("glitch", 15);
      check_val("glitch_active", {31'd0, active_profile}, 32'd0);

      // Reset while the K write is stalled
      profile_sel = 1'b1;
      n = 0;
      while (!(mgmt_write && mgmt_address == 6'd7) && n < 100) begin
         tick();
         n++;
      end
      mgmt_waitrequest = 1'b1;
      tick();
      tick();
      check_val("rstmid_held_wr",   {31'd0, mgmt_write}, 32'd1);
      check_val("rstmid_held_addr", {26'd0, mgmt_address}, 32'd7);
      reset = 1'b1;
      tick();
      check_val("rstmid_write", {31'd0, mgmt_write}, 32'd0);
      check_val("rstmid_addr",  {26'd0, mgmt_address}, 32'd0);
      check_val("rstmid_busy",  {31'd0, busy}, 32'd0);
      reset            = 1'b0;
      mgmt_waitrequest = 1'b0;
      run_seq("rstmid_restart", 1'b1, 0, 1'b0, 1'b0, 0, 1'b0);

`ifdef PLL_RECONFIG_LOCK_WAIT_EN
      // Lock never returns: timeout and done, then the next start clears it
      profile_sel = 1'b0;
      run_seq("tmo", 1'b0, 0, 1'b0, 1'b0, 1, 1'b1);
      tick();
      check_val("tmo_sticky", {31'd0, timeout}, 32'd1);
      profile_sel = 1'b1;
      run_seq("tmo_clr", 1'b1, 0, 1'b0, 1'b0, 0, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   // Absolute bound in case the DUT stops responding altogether.
   initial begin
      #(60000 * 20);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
